// File: rtl/uart_pkg.sv
// Shared UART definitions: receive checker states, end-of-line byte and the
// loopback self-test message also used by the transmit driver.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_ACK,
        RX_CHECK,
        RX_DISCARD,
        RX_DONE
    } rx_state_t;

    localparam logic [7:0] TERMINATOR_DEFAULT = 8'd10;

    localparam int unsigned HELLO_LEN = 13;

    // "Hello World!\n"
    localparam logic [7:0] HELLO_MSG [HELLO_LEN] = '{
        8'd72, 8'd101, 8'd108, 8'd108, 8'd111, 8'd32, 8'd87,
        8'd111, 8'd114, 8'd108, 8'd100, 8'd33, 8'd10
    };

endpackage

// File: rtl/rx_handshake.sv
// Level handshake with the UART receiver: strobes capture once per byte and
// holds the acknowledge until the receiver drops its full flag.
module rx_handshake (
    input  logic Clock,
    input  logic Reset,
    input  logic arm,
    input  logic rx_full,
    output logic rx_read,
    output logic capture,
    output logic released
);

    // Gating on !rx_read ensures a byte held high for many cycles is taken once.
    always_comb begin
        capture  = arm && rx_full && !rx_read;
        released = rx_read && !rx_full;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rx_read <= 1'b0;
        end else if (capture) begin
            rx_read <= 1'b1;
        end else if (released) begin
            rx_read <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_line_checker.sv
// Assembles received bytes into terminated lines and judges each line against
// the expected loopback message; keeps line and error statistics.
module rx_line_checker
    import uart_pkg::*;
#(
    parameter int unsigned MSG_LEN    = HELLO_LEN,
    parameter int unsigned MAX_LEN    = 16,
    parameter logic [7:0]  TERMINATOR = TERMINATOR_DEFAULT
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       RxFull,
    input  logic [7:0] RxData,
    input  logic       FrameErr,
    output logic       RxRead,
    output logic       LineDone,
    output logic       Match,
    output logic [7:0] LineCount,
    output logic [7:0] ErrCount,
    output logic [7:0] LastByte
);

    localparam int unsigned IDX_W = $clog2(MAX_LEN);
    localparam logic [IDX_W-1:0] MSG_LAST = IDX_W'(MSG_LEN - 1);
    localparam logic [IDX_W-1:0] MAX_LAST = IDX_W'(MAX_LEN - 1);

    rx_state_t        state, state_n;
    logic [IDX_W-1:0] index, index_n;
    logic             bad, bad_n;
    logic [7:0]       last_byte_n;
    logic             line_done_n, match_n;
    logic [7:0]       line_count_n, err_count_n;
    logic [7:0]       expected;
    logic             arm, capture, released;

    assign arm = (state == RX_IDLE) || (state == RX_DISCARD);

    rx_handshake u_handshake (
        .Clock    (Clock),
        .Reset    (Reset),
        .arm      (arm),
        .rx_full  (RxFull),
        .rx_read  (RxRead),
        .capture  (capture),
        .released (released)
    );

    always_comb begin
        expected = '0;
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            if (index == IDX_W'(i)) begin
                expected = HELLO_MSG[4'(i)];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= RX_IDLE;
            index     <= '0;
            bad       <= 1'b0;
            LastByte  <= '0;
            LineDone  <= 1'b0;
            Match     <= 1'b0;
            LineCount <= '0;
            ErrCount  <= '0;
        end else begin
            state     <= state_n;
            index     <= index_n;
            bad       <= bad_n;
            LastByte  <= last_byte_n;
            LineDone  <= line_done_n;
            Match     <= match_n;
            LineCount <= line_count_n;
            ErrCount  <= err_count_n;
        end
    end

    always_comb begin
        state_n      = state;
        index_n      = index;
        bad_n        = bad;
        last_byte_n  = LastByte;
        line_done_n  = 1'b0;
        match_n      = Match;
        line_count_n = LineCount;
        err_count_n  = ErrCount;

        case (state)
            RX_IDLE: begin
                if (capture) begin
                    last_byte_n = RxData;
                    bad_n       = bad | FrameErr;
                    state_n     = RX_ACK;
                end
            end
            RX_ACK: begin
                if (released) begin
                    state_n = RX_CHECK;
                end
            end
            RX_CHECK: begin
                if (index > MSG_LAST || LastByte != expected) begin
                    bad_n = 1'b1;
                end
                if (LastByte == TERMINATOR) begin
                    state_n = RX_DONE;
                end else if (index == MAX_LAST) begin
                    bad_n   = 1'b1;
                    state_n = RX_DISCARD;
                end else begin
                    index_n = index + 1'b1;
                    state_n = RX_IDLE;
                end
            end
            RX_DISCARD: begin
                // Capture and release alternate here; the line closes once the
                // terminator byte has been fully acknowledged.
                if (capture) begin
                    last_byte_n = RxData;
                end else if (released && LastByte == TERMINATOR) begin
                    state_n = RX_DONE;
                end
            end
            RX_DONE: begin
                line_done_n  = 1'b1;
                match_n      = !bad && (index == MSG_LAST);
                line_count_n = LineCount + 8'd1;
                if (!match_n && ErrCount != 8'hFF) begin
                    err_count_n = ErrCount + 8'd1;
                end
                index_n = '0;
                bad_n   = 1'b0;
                state_n = RX_IDLE;
            end
            default: begin
                index_n = '0;
                bad_n   = 1'b0;
                state_n = RX_IDLE;
            end
        endcase
    end

endmodule
